// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
//   Game-side responder for the hiscore engine's RAM access interface. Sits
//   between the CPU work-RAM port and a single-port work RAM (1-cycle read
//   latency). Hiscore reads/writes are slotted into CPU idle cycles, take the
//   RAM outright while hs_pause is high, and steal a CPU cycle once the
//   hiscore side has been denied STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   hs_address/hs_data_in         hiscore address / write data
//   hs_write                      rising edge requests one write
//   hs_pause                      CPU halted, every cycle is a hiscore slot
//   hs_data_out, hs_ready         read data, valid when hs_ready
//   overrun                       sticky: a pending write was replaced
//   cpu_addr/din/we/ce            CPU RAM request
//   cpu_wait, cpu_dout            CPU stall (hold request), CPU read data
//   ram_addr/din/we, ram_dout     single-port RAM
//
// state   | meaning
// IDLE    | waiting for a slot with a pending hiscore access
// WR      | hiscore write was issued last cycle, RAM back to CPU
// RD_WAIT | hiscore read in flight, ram_dout valid this cycle

module hiscore_ram_port #(
  parameter int AW           = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  input  logic          hs_pause,
  output logic [7:0]    hs_data_out,
  output logic          hs_ready,
  output logic          overrun,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  input  logic          cpu_ce,
  output logic          cpu_wait,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic [7:0]    starve_cnt;
  logic          rd_pend, wr_pend;
  logic [AW-1:0] last_addr, wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic          last_write;

  logic slot, issue_wr, issue_rd, addr_chg, wr_edge, rd_ok;

  assign slot     = hs_pause | ~cpu_ce | (starve_cnt >= LIMIT);
  assign addr_chg = (hs_address != last_addr);
  assign wr_edge  = hs_write & ~last_write;
  // A read in flight is only usable if the address it was issued for is
  // still the requested one and did not move during the data cycle.
  assign rd_ok    = (hs_address == rd_addr) & ~addr_chg;
  assign cpu_dout = ram_dout;

  always_comb begin
    state_nxt = state;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    ram_addr  = cpu_addr;
    ram_din   = cpu_din;
    ram_we    = cpu_we & cpu_ce & ~hs_pause;
    case (state)
      IDLE: begin
        if (slot && wr_pend) begin
          issue_wr  = 1'b1;
          state_nxt = WR;
          ram_addr  = wr_addr;
          ram_din   = wr_data;
          ram_we    = 1'b1;
        end else if (slot && rd_pend) begin
          issue_rd  = 1'b1;
          state_nxt = RD_WAIT;
          ram_addr  = hs_address;
          ram_we    = 1'b0;
        end
      end
      WR:      state_nxt = IDLE;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // No RAM write may escape while reset is held, whatever the CPU drives.
    if (!reset_n) ram_we = 1'b0;
    cpu_wait = reset_n & cpu_ce & ~hs_pause & (issue_wr | issue_rd);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_data_out <= 8'h00;
      hs_ready    <= 1'b0;
      overrun     <= 1'b0;
      starve_cnt  <= 8'h00;
      rd_pend     <= 1'b1;
      wr_pend     <= 1'b0;
      last_addr   <= '0;
      last_write  <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      rd_addr     <= '0;
    end else begin
      last_addr  <= hs_address;
      last_write <= hs_write;

      if (issue_rd) rd_addr <= hs_address;

      // A read issued this cycle already uses the new address, so an address
      // change only leaves a read pending if nothing was issued for it.
      if (wr_edge)       rd_pend <= 1'b1;
      else if (issue_rd) rd_pend <= 1'b0;
      else if (addr_chg) rd_pend <= 1'b1;

      if (wr_edge) begin
        wr_pend <= 1'b1;
        wr_addr <= hs_address;
        wr_data <= hs_data_in;
        if (wr_pend && !issue_wr) overrun <= 1'b1;
      end else if (issue_wr) begin
        wr_pend <= 1'b0;
      end

      if (state == RD_WAIT && rd_ok) hs_data_out <= ram_dout;

      if (addr_chg || wr_edge)
        hs_ready <= 1'b0;
      else if (state == RD_WAIT && rd_ok && !rd_pend && !wr_pend)
        hs_ready <= 1'b1;

      if (issue_wr || issue_rd || !(rd_pend || wr_pend))
        starve_cnt <= 8'h00;
      else if (state == IDLE && !slot && starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_port.sv
module tb_hiscore_ram_port;

  logic        clk, reset_n;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write, hs_pause;
  logic [7:0]  hs_data_out;
  logic        hs_ready, overrun;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we, cpu_ce, cpu_wait;
  logic [7:0]  cpu_dout;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  int checks = 0;
  int failures = 0;
  int rst_we_cnt = 0;
  int wr41_cnt = 0;

  logic [7:0] mem [0:65535];

  hiscore_ram_port #(.AW(16), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_pause(hs_pause), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
    .overrun(overrun),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_ce(cpu_ce),
    .cpu_wait(cpu_wait), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (!reset_n && ram_we) rst_we_cnt <= rst_we_cnt + 1;
    if (reset_n && ram_we && ram_addr == 16'h0041) wr41_cnt <= wr41_cnt + 1;
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd3;
    return t ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (!hs_ready && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_ready_timeout"}, {31'd0, hs_ready}, 32'd1);
  endtask

  typedef struct {
    logic        pause;
    logic        ce;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [15:0] exp_addr;
    logic [7:0]  exp_din;
    logic        exp_we;
    logic        exp_wait;
  } vec_t;

  vec_t vecs[6];

  // Random-phase state
  logic [7:0] shadow [0:63];
  logic [7:0] cpu_shadow [0:255];
  logic       prev_wait = 1'b0;
  logic       cpu_rd_valid = 1'b0;
  logic [7:0] cpu_rd_exp = 8'h00;

  task automatic rnd_cycle();
    if (!prev_wait) begin
      cpu_ce   = ($urandom_range(0, 9) < 7);
      cpu_we   = $urandom_range(0, 1);
      cpu_addr = 16'h8000 | 16'($urandom_range(0, 255));
      cpu_din  = 8'($urandom);
    end
    #1;
    if (cpu_rd_valid) chk("cpu_read", {24'd0, cpu_dout}, {24'd0, cpu_rd_exp});
    cpu_rd_valid = 1'b0;
    if (cpu_wait) chk("wait_legal", {30'd0, cpu_ce, hs_pause}, 32'b10);
    if (cpu_ce && !hs_pause && !cpu_wait) begin
      chk("cpu_mux_addr", {16'd0, ram_addr}, {16'd0, cpu_addr});
      chk("cpu_mux_we", {31'd0, ram_we}, {31'd0, cpu_we});
      if (cpu_we) chk("cpu_mux_din", {24'd0, ram_din}, {24'd0, cpu_din});
      cpu_rd_exp   = cpu_shadow[cpu_addr[7:0]];
      cpu_rd_valid = 1'b1;
      if (cpu_we) cpu_shadow[cpu_addr[7:0]] = cpu_din;
    end
    prev_wait = cpu_wait;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
    mem[16'h0123] = 8'h5A;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h9001, 8'h11, 16'h9001, 8'h11, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h9002, 8'h22, 16'h9002, 8'h22, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h9003, 8'h33, 16'h9003, 8'h33, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h9004, 8'h44, 16'h9004, 8'h44, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'hBEEF, 8'hC3, 16'hBEEF, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h9006, 8'h66, 16'h9006, 8'h66, 1'b0, 1'b0};

    // Reset values
    reset_n = 1'b0; hs_address = 16'h0123; hs_data_in = 8'h00; hs_write = 1'b0;
    hs_pause = 1'b0; cpu_addr = 16'h9000; cpu_din = 8'hFF; cpu_we = 1'b1; cpu_ce = 1'b1;
    tick(); tick();
    chk("rst_data_out", {24'd0, hs_data_out}, 32'd0);
    chk("rst_ready", {31'd0, hs_ready}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);

    // Read of address present at reset, paused CPU
    hs_pause = 1'b1; cpu_we = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("s1_ram_addr", {16'd0, ram_addr}, 32'h0123);
    chk("s1_ram_we", {31'd0, ram_we}, 32'd0);
    tick(); tick();
    chk("s1_ready", {31'd0, hs_ready}, 32'd1);
    chk("s1_data", {24'd0, hs_data_out}, 32'h5A);

    // Table: RAM mux with nothing pending
    for (int i = 0; i < 6; i++) begin
      hs_pause = vecs[i].pause; cpu_ce = vecs[i].ce; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_addr", i), {16'd0, ram_addr}, {16'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_din", i), {24'd0, ram_din}, {24'd0, vecs[i].exp_din});
      chk($sformatf("vec%0d_we", i), {31'd0, ram_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_wait", i), {31'd0, cpu_wait}, {31'd0, vecs[i].exp_wait});
      tick();
    end

    // Write slotted into CPU idle cycles
    hs_pause = 1'b0; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h9100;
    hs_write = 1'b1; hs_address = 16'h0200; hs_data_in = 8'hA5;
    #1;
    chk("s2_edge_wait", {31'd0, cpu_wait}, 32'd0);
    chk("s2_edge_addr", {16'd0, ram_addr}, 32'h9100);
    tick();
    hs_write = 1'b0; cpu_ce = 1'b0;
    #1;
    chk("s2_wr_we", {31'd0, ram_we}, 32'd1);
    chk("s2_wr_addr", {16'd0, ram_addr}, 32'h0200);
    chk("s2_wr_din", {24'd0, ram_din}, 32'hA5);
    chk("s2_wr_wait", {31'd0, cpu_wait}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      cpu_ce = ~cpu_ce;
      #1;
      chk("s2_alt_wait", {31'd0, cpu_wait}, 32'd0);
      if (cpu_ce) chk("s2_alt_addr", {16'd0, ram_addr}, 32'h9100);
    end
    tick();
    chk("s2_ready", {31'd0, hs_ready}, 32'd1);
    chk("s2_data", {24'd0, hs_data_out}, 32'hA5);

    // Starvation: CPU never idles
    cpu_ce = 1'b1; cpu_addr = 16'h9200; hs_address = 16'h0300;
    #1;
    chk("s3_c0_wait", {31'd0, cpu_wait}, 32'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("s3_deny%0d_wait", i + 1), {31'd0, cpu_wait}, 32'd0);
      tick();
    end
    #1;
    chk("s3_steal_wait", {31'd0, cpu_wait}, 32'd1);
    chk("s3_steal_addr", {16'd0, ram_addr}, 32'h0300);
    tick();
    #1;
    chk("s3_after_wait", {31'd0, cpu_wait}, 32'd0);
    chk("s3_after_addr", {16'd0, ram_addr}, 32'h9200);
    tick();
    chk("s3_ready", {31'd0, hs_ready}, 32'd1);
    chk("s3_data", {24'd0, hs_data_out}, {24'd0, init_val(16'h0300)});

    // Write edge together with an address change
    cpu_ce = 1'b0;
    hs_address = 16'h0010; hs_data_in = 8'h3C; hs_write = 1'b1;
    tick();
    hs_write = 1'b0;
    wait_ready(20, "s4");
    chk("s4_data", {24'd0, hs_data_out}, 32'h3C);

    // Address moves while the read is in flight
    hs_address = 16'h0040;
    tick();
    #1;
    chk("s5_issue_addr", {16'd0, ram_addr}, 32'h0040);
    tick();
    hs_address = 16'h0041;
    tick();
    chk("s5_stale_ready", {31'd0, hs_ready}, 32'd0);
    chk("s5_stale_data", {24'd0, hs_data_out}, 32'h3C);
    #1;
    chk("s5_reissue_addr", {16'd0, ram_addr}, 32'h0041);
    tick(); tick();
    chk("s5_ready", {31'd0, hs_ready}, 32'd1);
    chk("s5_data", {24'd0, hs_data_out}, {24'd0, init_val(16'h0041)});

    // Overrun: second edge while first write still pending
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h9300;
    wr41_cnt = 0;
    hs_write = 1'b1; hs_data_in = 8'h11;
    tick();
    hs_write = 1'b0;
    tick();
    hs_write = 1'b1; hs_data_in = 8'h22;
    tick();
    hs_write = 1'b0;
    #1;
    chk("s6_overrun", {31'd0, overrun}, 32'd1);
    cpu_ce = 1'b0;
    wait_ready(20, "s6");
    chk("s6_data", {24'd0, hs_data_out}, 32'h22);
    chk("s6_write_count", wr41_cnt, 32'd1);
    chk("s6_mem", {24'd0, mem[16'h0041]}, 32'h22);

    // Reset in the middle of RD_WAIT
    hs_address = 16'h0050;
    tick(); tick();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9400;
    reset_n = 1'b0;
    #1;
    chk("s7_data", {24'd0, hs_data_out}, 32'd0);
    chk("s7_ready", {31'd0, hs_ready}, 32'd0);
    chk("s7_overrun", {31'd0, overrun}, 32'd0);
    chk("s7_ram_we", {31'd0, ram_we}, 32'd0);
    chk("s7_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    tick(); tick(); tick();
    chk("s7_no_write", rst_we_cnt, 32'd0);
    cpu_we = 1'b0; cpu_ce = 1'b0;
    reset_n = 1'b1;
    wait_ready(20, "s7");
    chk("s7_data_after", {24'd0, hs_data_out}, {24'd0, init_val(16'h0050)});

    // Randomized traffic against a behavioural model
    for (int i = 0; i < 64; i++) shadow[i] = init_val(16'h0400 + 16'(i));
    for (int i = 0; i < 256; i++) cpu_shadow[i] = init_val(16'h8000 + 16'(i));
    hs_address = 16'h0400;
    wait_ready(20, "rnd_start");
    for (int t = 0; t < 200; t++) begin
      int idx, n;
      logic do_wr;
      hs_pause = ($urandom_range(0, 3) == 0);
      idx   = $urandom_range(0, 63);
      do_wr = $urandom_range(0, 1);
      hs_address = 16'h0400 + 16'(idx);
      if (do_wr) begin
        hs_data_in  = 8'($urandom);
        hs_write    = 1'b1;
        shadow[idx] = hs_data_in;
      end
      rnd_cycle();
      hs_write = 1'b0;
      n = 0;
      while (!hs_ready && n < 60) begin
        rnd_cycle();
        n++;
      end
      chk("rnd_ready_timeout", {31'd0, hs_ready}, 32'd1);
      chk("rnd_data", {24'd0, hs_data_out}, {24'd0, shadow[idx]});
    end
    chk("rnd_overrun", {31'd0, overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
